// File: rtl/ascii_pkg.sv
// ============================================================================
// Module      : ascii_pkg
// Description : ASCII constants, byte type and buffer state encoding shared by
//               the lower-case and upper-case stream converters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascii_pkg;

    localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
    localparam int         ASCII_CASE_BIT = 5;

    typedef logic [7:0] ascii_byte_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    function automatic logic is_upper(input ascii_byte_t b);
        return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
    endfunction

    function automatic ascii_byte_t to_lower(input ascii_byte_t b);
        ascii_byte_t r;
        r = b;
        if (is_upper(b)) begin
            r[ASCII_CASE_BIT] = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_skid_buf.sv
// ============================================================================
// Module      : byte_skid_buf
// Description : Generic 2-entry valid/ready elastic buffer with registered
//               in_ready and registered output payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_skid_buf
    import ascii_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_payload_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_payload_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("byte_skid_buf supports DEPTH=2 only");
    end

    buf_state_t   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         w_in_xfer;
    logic         w_out_xfer;

    assign w_in_xfer  = in_valid_i && in_ready_q;
    assign w_out_xfer = out_valid_q && out_ready_i;

    // head is the presented entry; tail only holds a byte while FULL
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (w_in_xfer) begin
                    head_d  = in_payload_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    head_d = in_payload_i;
                end else if (w_in_xfer) begin
                    tail_d  = in_payload_i;
                    state_d = FULL;
                end else if (w_out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_payload_o = head_q;

endmodule

`default_nettype wire

// File: rtl/ascii_tolower_stream.sv
// ============================================================================
// Module      : ascii_tolower_stream
// Description : Streaming ASCII upper-to-lower case converter over a 2-entry
//               elastic buffer. Statistics counters are built only when the
//               macro ASCII_TOLOWER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_tolower_stream
    import ascii_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] conv_count
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("ascii_tolower_stream supports DEPTH=2 only");
    end

    ascii_byte_t w_lower;
    assign w_lower = to_lower(in_data);

`ifdef ASCII_TOLOWER_STATS_EN
    localparam int PW = 10;

    logic [PW-1:0]    w_in_payload;
    logic [PW-1:0]    w_out_payload;
    logic             w_out_conv;
    logic             w_out_xfer;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [CNT_W-1:0] conv_count_q, conv_count_d;

    assign w_in_payload = {in_last, is_upper(in_data), w_lower};
    assign out_last     = w_out_payload[9];
    assign w_out_conv   = w_out_payload[8];
    assign out_data     = w_out_payload[7:0];
    assign w_out_xfer   = out_valid && out_ready;

    // Counters saturate at all-ones rather than wrapping
    always_comb begin
        byte_count_d = byte_count_q;
        conv_count_d = conv_count_q;
        if (w_out_xfer) begin
            if (byte_count_q != {CNT_W{1'b1}}) begin
                byte_count_d = byte_count_q + CNT_W'(1);
            end
            if (w_out_conv && (conv_count_q != {CNT_W{1'b1}})) begin
                conv_count_d = conv_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count_q <= '0;
            conv_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign byte_count = byte_count_q;
    assign conv_count = conv_count_q;
`else
    localparam int PW = 9;

    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_out_payload;

    assign w_in_payload = {in_last, w_lower};
    assign out_last     = w_out_payload[8];
    assign out_data     = w_out_payload[7:0];
    assign byte_count   = '0;
    assign conv_count   = '0;
`endif

    byte_skid_buf #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk           (clk),
        .rst           (rst),
        .in_payload_i  (w_in_payload),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .out_payload_o (w_out_payload),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_ascii_tolower_stream.sv
// ============================================================================
// Module      : tb_ascii_tolower_stream
// Description : Self-checking bench for ascii_tolower_stream with a queue-based
//               reference model and table-driven case mapping vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascii_tolower_stream;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ASCII_TOLOWER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [CNT_W-1:0] byte_count;
    logic [CNT_W-1:0] conv_count;

    ascii_tolower_stream #(
        .DEPTH (2),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .byte_count (byte_count),
        .conv_count (conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        bit         conv;
    } ent_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dexp;
    } vec_t;

    ent_t       q[$];
    logic [7:0] cap[$];
    int         m_bytes;
    int         m_conv;
    int         nout;
    int         last_cnt;
    logic [7:0] last_data;
    int         checks;
    int         failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t model_byte(input logic [7:0] b, input logic l);
        ent_t e;
        e.conv = (b >= 8'd65) && (b <= 8'd90);
        e.data = e.conv ? b + 8'd32 : b;
        e.last = l;
        return e;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance model
    task automatic do_cycle(input logic v, input logic [7:0] d, input logic l,
                            input logic r, output logic acc);
        logic ixf;
        logic oxf;
        ent_t e;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("byte_count", 32'(byte_count), STATS ? 32'(m_bytes) : 32'd0);
        chk("conv_count", 32'(conv_count), STATS ? 32'(m_conv) : 32'd0);
        ixf = v && in_ready;
        oxf = out_valid && r;
        if (oxf) begin
            nout++;
            cap.push_back(out_data);
            if (out_last) begin
                last_cnt++;
                last_data = out_data;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_last", 32'(out_last), 32'(e.last));
                if (m_bytes < CMAX) m_bytes++;
                if (e.conv && m_conv < CMAX) m_conv++;
            end
        end
        if (ixf) q.push_back(model_byte(d, l));
        acc = ixf;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        cap.delete();
        m_bytes  = 0;
        m_conv   = 0;
        last_cnt = 0;
        last_data = 8'h00;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        chk("rst_conv_count", 32'(conv_count), 32'd0);
    endtask

    initial begin
        vec_t       tbl[8];
        logic       acc;
        logic       jdone;
        logic [7:0] d;
        logic [7:0] frame[4];
        int         n_acc;
        int         n0;

        checks   = 0;
        failures = 0;
        nout     = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{8'h41, 8'h61};
        tbl[1] = '{8'h5A, 8'h7A};
        tbl[2] = '{8'h61, 8'h61};
        tbl[3] = '{8'h7A, 8'h7A};
        tbl[4] = '{8'h40, 8'h40};
        tbl[5] = '{8'h5B, 8'h5B};
        tbl[6] = '{8'h60, 8'h60};
        tbl[7] = '{8'h7B, 8'h7B};

        // Case mapping stream, one byte per cycle after one cycle of latency
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk("map_valid", 32'(out_valid), 32'd1);
                chk("map_data", 32'(out_data), 32'(tbl[i-1].dexp));
            end
            if (i < 8) d = tbl[i].din;
            else       d = 8'h00;
            do_cycle(i < 8, d, 1'b0, 1'b1, acc);
        end
        chk("map_byte_count", 32'(byte_count), STATS ? 32'd8 : 32'd0);
        chk("map_conv_count", 32'(conv_count), STATS ? 32'd2 : 32'd0);

        // Back-pressure: third byte is refused while output is stalled
        do_reset();
        do_cycle(1'b1, "H", 1'b0, 1'b0, acc);
        chk("bp_acc_H", 32'(acc), 32'd1);
        do_cycle(1'b1, "I", 1'b0, 1'b0, acc);
        chk("bp_acc_I", 32'(acc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h68);
            do_cycle(1'b1, "J", 1'b0, 1'b0, acc);
            chk("bp_acc_J_stalled", 32'(acc), 32'd0);
        end
        cap.delete();
        jdone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            do_cycle(!jdone, "J", 1'b0, 1'b1, acc);
            if (acc) jdone = 1'b1;
        end
        chk("bp_out_count", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            chk("bp_out0", 32'(cap[0]), 32'h68);
            chk("bp_out1", 32'(cap[1]), 32'h69);
            chk("bp_out2", 32'(cap[2]), 32'h6A);
        end

        // Simultaneous transfers in ONE: full throughput
        do_reset();
        do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, acc);
        n_acc = 0;
        n0 = nout;
        for (int k = 0; k < 100; k++) begin
            do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, acc);
            if (acc) n_acc++;
        end
        chk("thru_in", 32'(n_acc), 32'd100);
        chk("thru_out", 32'(nout - n0), 32'd100);

        // Frame with last on the final byte
        do_reset();
        frame[0] = "A"; frame[1] = "B"; frame[2] = "C"; frame[3] = "D";
        for (int k = 0; k < 4; k++) do_cycle(1'b1, frame[k], k == 3, 1'b1, acc);
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("last_count", 32'(last_cnt), 32'd1);
        chk("last_data", 32'(last_data), 32'h64);

        // Reset while FULL drops the buffered bytes
        do_reset();
        do_cycle(1'b1, "X", 1'b0, 1'b0, acc);
        do_cycle(1'b1, "Y", 1'b0, 1'b0, acc);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        do_reset();
        do_cycle(1'b1, "Q", 1'b0, 1'b1, acc);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h71);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);

        // Counter saturation
        do_reset();
        for (int k = 0; k < 20; k++) do_cycle(1'b1, "A", 1'b0, 1'b1, acc);
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("sat_byte_count", 32'(byte_count), STATS ? 32'(CMAX) : 32'd0);
        chk("sat_conv_count", 32'(conv_count), STATS ? 32'(CMAX) : 32'd0);

        // Random valid/ready/data patterns
        do_reset();
        for (int k = 0; k < 400; k++) begin
            do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        end
        for (int k = 0; k < 4; k++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ascii_tolower_stream.md
Name: ascii_tolower_stream

Overview:
- Streaming ASCII case converter, the inverse of the team's uppercase block: maps 'A'..'Z' (0x41..0x5A) to 'a'..'z' by setting bit 5; all other bytes pass unchanged.
- Sits on the byte path between the character source and the display/UART sink.
- valid/ready handshake on both sides; 2-entry elastic buffer gives full throughput with registered in_ready.

Parameters:
- DEPTH, 2, buffer entries (fixed 2; other values unsupported, assert at elaboration).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  input byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a byte this cycle.
- in_last  in  1  marks the final byte of a frame; travels with data.
- out_data  out  8  converted byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts.
- out_last  out  1  in_last delayed with its byte.
- byte_count  out  CNT_W  bytes emitted (stats).
- conv_count  out  CNT_W  bytes actually case-changed (stats).

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, in_ready=1, both counters=0, buffer empty. Reset mid-transfer drops buffered bytes; no partial output after reset.
- Conversion: is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A). Stored byte = in_data | 8'h20 when is_upper, else in_data. Conversion happens at write into the buffer, so out_data is always a registered value.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Latency: byte accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 at the earliest.
- Buffer FSM, states EMPTY, ONE, FULL:
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output transfer in the same cycle -> ONE (head replaced).
    - Input only -> FULL.
    - Output only -> EMPTY.
  - FULL: in_ready=0, out_valid=1. Output transfer -> ONE (second entry promoted to head).
- in_ready is a register output; no combinational path from out_ready to in_ready.
- out_data and out_last must stay stable while out_valid=1 and out_ready=0.
- Order is preserved. No byte is dropped or duplicated under any valid/ready pattern.
- byte_count increments on each output transfer.
- conv_count increments on each output transfer whose byte was converted. A per-entry converted flag is stored with the byte.
- Both counters saturate at 2^CNT_W-1 and do not wrap.

Optional Feature:
- Macro: ASCII_TOLOWER_STATS_EN.
- Defined: byte_count and conv_count are implemented as above.
- Undefined: counters and the per-entry converted flag are not built; byte_count and conv_count are tied to 0. Ports stay present so the interface is unchanged.

Decomposition:
- Package ascii_pkg:
  - ASCII_UPPER_A=8'h41, ASCII_UPPER_Z=8'h5A, ASCII_CASE_BIT=5.
  - Typedef ascii_byte_t (logic [7:0]).
  - Enum buf_state_t {EMPTY, ONE, FULL}.
  - The same package also serves the existing uppercase path.
- One natural sub-module: byte_skid_buf, a generic 2-entry valid/ready buffer carrying {last, flag, data}. The converter instantiates it and adds the case logic and counters.

Test Plan:
- Case mapping: stream "AZaz@[`{" (0x41,0x5A,0x61,0x7A,0x40,0x5B,0x60,0x7B) with out_ready=1 -> outputs 0x61,0x7A,0x61,0x7A,0x40,0x5B,0x60,0x7B, one per cycle after 1-cycle latency; conv_count=2, byte_count=8.
- Back-pressure: hold out_ready=0, drive 3 bytes 'H','I','J' -> in_ready drops after 2 accepts; out_data holds 0x68. Then release -> 0x68,0x69,0x6A in order, no loss.
- Simultaneous: in state ONE with in_valid=out_ready=1 for 100 cycles of random bytes -> throughput 1 byte/cycle, data matches reference model.
- Last flag: 4-byte frame "ABCD" with in_last on 'D' -> out_last=1 only alongside 0x64.
- Reset mid-operation: fill buffer (FULL), assert rst one cycle -> next cycle out_valid=0, in_ready=1, counters 0; following input 'Q' emerges as 0x71.
- Saturation (CNT_W=4, stats enabled): send 20 'A' -> byte_count and conv_count stick at 15. With the macro undefined -> both read 0 throughout.
